// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares a single-port register file between writeback (WB), two-operand
//   fetch (OP) and debug (DBG). At most one regfile access per cycle.
//   Grant priority: WB, then DBG once it has waited DBG_MAX_WAIT cycles,
//   then OP, then DBG. Each OP fetch is issued as two reads (A then B);
//   WB writes to the latched A register are forwarded into op_data_a until
//   the B read is issued.
// Ports
//   clock, reset_n                  rising-edge clock, async active-low reset
//   wb_req/wb_addr/wb_data          writeback write, never stalled
//   op_req/op_addr_a/op_addr_b      operand fetch request (level)
//   op_valid/op_data_a/op_data_b    one-cycle result pulse and held operands
//   dbg_req/dbg_we/dbg_addr/dbg_wdata  debug access request (level)
//   dbg_ack/dbg_rdata               ack pulse the cycle after grant, read data
//   rf_addr/rf_we/rf_din            regfile access (combinational from grant)
//   rf_dout                         regfile read data, valid cycle after read
module regfile_port_arbiter #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              op_req,
  input  logic [ADDR_W-1:0] op_addr_a,
  input  logic [ADDR_W-1:0] op_addr_b,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_data_a,
  output logic [DATA_W-1:0] op_data_b,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISS_B = 2'd1;
  localparam logic [1:0] CAP_B = 2'd2;

  localparam int WAIT_W = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);

  logic [1:0]        state;
  logic              a_first;     // first ISS_B cycle: rf_dout holds operand A
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic              dbg_rd_q;    // granted debug access was a read
  logic [DATA_W-1:0] dbg_rdata_q;
  logic [WAIT_W-1:0] dbg_wait;

  logic dbg_elig;
  logic dbg_urgent;
  logic op_want;
  logic gnt_wb;
  logic gnt_dbg;
  logic gnt_op;

  // DBG may not be granted in its own ack cycle.
  assign dbg_elig   = dbg_req && !dbg_ack;
  assign dbg_urgent = dbg_elig && (dbg_wait == WAIT_MAX);
  assign op_want    = ((state == IDLE) && op_req) || (state == ISS_B);

  assign gnt_wb  = wb_req;
  assign gnt_dbg = !wb_req && dbg_elig && (dbg_urgent || !op_want);
  assign gnt_op  = !wb_req && op_want && !dbg_urgent;

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_din  = '0;
    if (reset_n) begin
      if (gnt_wb) begin
        rf_we   = 1'b1;
        rf_addr = wb_addr;
        rf_din  = wb_data;
      end else if (gnt_dbg) begin
        rf_we   = dbg_we;
        rf_addr = dbg_addr;
        rf_din  = dbg_wdata;
      end else if (gnt_op) begin
        rf_addr = (state == IDLE) ? op_addr_a : addr_b_q;
      end
    end
  end

  // Read data arrives in the ack cycle itself, so it is passed straight
  // through then and held from the register afterwards.
  assign dbg_rdata = (dbg_ack && dbg_rd_q) ? rf_dout : dbg_rdata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      a_first     <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      op_valid    <= 1'b0;
      op_data_a   <= '0;
      op_data_b   <= '0;
      dbg_ack     <= 1'b0;
      dbg_rd_q    <= 1'b0;
      dbg_rdata_q <= '0;
      dbg_wait    <= '0;
    end else begin
      op_valid <= 1'b0;
      dbg_ack  <= gnt_dbg;

      if (gnt_dbg) begin
        dbg_rd_q <= !dbg_we;
      end
      if (dbg_ack && dbg_rd_q) begin
        dbg_rdata_q <= rf_dout;
      end

      if (gnt_dbg) begin
        dbg_wait <= '0;
      end else if (dbg_elig && (dbg_wait != WAIT_MAX)) begin
        dbg_wait <= dbg_wait + WAIT_W'(1);
      end

      case (state)
        IDLE: begin
          if (gnt_op) begin
            addr_a_q <= op_addr_a;
            addr_b_q <= op_addr_b;
            a_first  <= 1'b1;
            state    <= ISS_B;
          end
        end
        ISS_B: begin
          a_first <= 1'b0;
          // A WB to addr_a always holds the port, so B cannot issue in
          // the same cycle; forwarded data overrides the captured read.
          if (wb_req && (wb_addr == addr_a_q)) begin
            op_data_a <= wb_data;
          end else if (a_first) begin
            op_data_a <= rf_dout;
          end
          if (gnt_op) begin
            state <= CAP_B;
          end
        end
        CAP_B: begin
          op_data_b <= rf_dout;
          op_valid  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
